// File: rtl/stopwatch_counter.sv
// Four-digit BCD stopwatch (M:SS.t) with start/pause on go rising edges,
// synchronous clear, up/down counting and a sticky wrap flag.
module stopwatch_counter #(
    parameter int DVSR = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       clr,
    input  logic       up,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic       run,
    output logic       ovf
);

    localparam int PW = $clog2(DVSR);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          go_q;
    logic          go_armed;
    logic          go_edge;
    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    d3_next;
    logic [3:0]    d2_next;
    logic [3:0]    d1_next;
    logic [3:0]    d0_next;
    logic          wrap;

    // go_armed blocks a go level held across reset release from counting as an edge.
    assign go_edge = go & ~go_q & go_armed;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_q     <= 1'b0;
            go_armed <= 1'b0;
        end else begin
            go_q <= go;
            if (!go) go_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else if (go_edge) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (state_next == IDLE) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    // Carry/borrow chain; bounds use >= so a corrupted digit still recovers to BCD.
    always_comb begin
        d3_next = hex3;
        d2_next = hex2;
        d1_next = hex1;
        d0_next = hex0;
        wrap    = 1'b0;
        if (up) begin
            if (hex0 < 4'd9) begin
                d0_next = hex0 + 4'd1;
            end else begin
                d0_next = 4'd0;
                if (hex1 < 4'd9) begin
                    d1_next = hex1 + 4'd1;
                end else begin
                    d1_next = 4'd0;
                    if (hex2 < 4'd5) begin
                        d2_next = hex2 + 4'd1;
                    end else begin
                        d2_next = 4'd0;
                        if (hex3 < 4'd9) begin
                            d3_next = hex3 + 4'd1;
                        end else begin
                            d3_next = 4'd0;
                            wrap    = 1'b1;
                        end
                    end
                end
            end
        end else begin
            if (hex0 != 4'd0) begin
                d0_next = (hex0 > 4'd9) ? 4'd9 : hex0 - 4'd1;
            end else begin
                d0_next = 4'd9;
                if (hex1 != 4'd0) begin
                    d1_next = (hex1 > 4'd9) ? 4'd9 : hex1 - 4'd1;
                end else begin
                    d1_next = 4'd9;
                    if (hex2 != 4'd0) begin
                        d2_next = (hex2 > 4'd5) ? 4'd5 : hex2 - 4'd1;
                    end else begin
                        d2_next = 4'd5;
                        if (hex3 != 4'd0) begin
                            d3_next = (hex3 > 4'd9) ? 4'd9 : hex3 - 4'd1;
                        end else begin
                            d3_next = 4'd9;
                            wrap    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex3 <= 4'd0;
            hex2 <= 4'd0;
            hex1 <= 4'd0;
            hex0 <= 4'd0;
            ovf  <= 1'b0;
        end else if (state_next == IDLE) begin
            hex3 <= 4'd0;
            hex2 <= 4'd0;
            hex1 <= 4'd0;
            hex0 <= 4'd0;
            ovf  <= 1'b0;
        end else if (tick) begin
            hex3 <= d3_next;
            hex2 <= d2_next;
            hex1 <= d1_next;
            hex0 <= d0_next;
            if (wrap) ovf <= 1'b1;
        end
    end

    assign run    = (state == RUN);
    assign dp_out = (state == PAUSE) ? 4'b0101 : 4'b1101;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at DVSR=4: reset, counting, wraps,
// pause/resume timing, clear priority and asynchronous reset.
module tb_stopwatch_counter;

    localparam int DVSR = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       go    = 1'b0;
    logic       clr   = 1'b0;
    logic       up    = 1'b1;
    logic [3:0] hex3;
    logic [3:0] hex2;
    logic [3:0] hex1;
    logic [3:0] hex0;
    logic [3:0] dp_out;
    logic       run;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // {digits M,S,S,t | dp_out | run | ovf}
    logic [21:0] obs;
    logic [21:0] exp_v;
    assign obs = {hex3, hex2, hex1, hex0, dp_out, run, ovf};

    stopwatch_counter #(.DVSR(DVSR)) dut (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .clr    (clr),
        .up     (up),
        .hex3   (hex3),
        .hex2   (hex2),
        .hex1   (hex1),
        .hex0   (hex0),
        .dp_out (dp_out),
        .run    (run),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Go high across exactly one rising edge; returns just after that edge.
    task automatic pulse_go();
        go = 1'b1;
        step(1);
        go = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        exp_v = {16'h0000, 4'b1101, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        reset = 1'b0;
        step(2);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_after_release: got %h expected %h", obs, exp_v);
        end
        n_checks++;
    endtask

    task automatic test_first_tick();
        up = 1'b1;
        pulse_go();
        exp_v = {16'h0000, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL run_after_go: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(3);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL no_change_before_tick: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(1);
        exp_v = {16'h0001, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL first_tick_at_dvsr: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(36);
        exp_v = {16'h0010, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL one_second: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        do_clear();
    endtask

    task automatic test_up_wrap();
        up = 1'b1;
        pulse_go();
        step(DVSR * 5999);
        exp_v = {16'h9599, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL up_max: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(DVSR);
        exp_v = {16'h0000, 4'b1101, 1'b1, 1'b1};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL up_wrap: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(DVSR * 10);
        exp_v = {16'h0010, 4'b1101, 1'b1, 1'b1};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        do_clear();
        exp_v = {16'h0000, 4'b1101, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clr_drops_ovf: got %h expected %h", obs, exp_v);
        end
        n_checks++;
    endtask

    task automatic test_down_wrap();
        up = 1'b0;
        pulse_go();
        step(DVSR);
        exp_v = {16'h9599, 4'b1101, 1'b1, 1'b1};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL down_wrap: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(DVSR);
        exp_v = {16'h9598, 4'b1101, 1'b1, 1'b1};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL down_step: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        // Direction flips mid-period; the tick must still land DVSR after the last one.
        step(2);
        up = 1'b1;
        step(1);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL dir_change_no_early_tick: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(1);
        exp_v = {16'h9599, 4'b1101, 1'b1, 1'b1};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL dir_change_up: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        do_clear();
    endtask

    task automatic test_pause_resume();
        up = 1'b1;
        pulse_go();
        step(1);
        go = 1'b1;
        step(1);
        go = 1'b0;
        exp_v = {16'h0000, 4'b0101, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pause_entry: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(10);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pause_frozen: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        pulse_go();
        step(1);
        exp_v = {16'h0000, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL resume_hold: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(1);
        exp_v = {16'h0001, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL resume_tick_2_cycles: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        do_clear();
    endtask

    task automatic test_clr_priority();
        up = 1'b1;
        pulse_go();
        step(DVSR * 2074);
        exp_v = {16'h3274, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reach_3_27_4: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        clr = 1'b1;
        go  = 1'b1;
        step(1);
        clr = 1'b0;
        go  = 1'b0;
        exp_v = {16'h0000, 4'b1101, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clr_over_go: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(DVSR * 2);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_stays_zero: got %h expected %h", obs, exp_v);
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        up = 1'b1;
        pulse_go();
        step(DVSR * 15 + 2);
        exp_v = {16'h0015, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        #2;
        reset = 1'b1;
        go    = 1'b1;
        #1;
        exp_v = {16'h0000, 4'b1101, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_no_clk: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        step(2);
        reset = 1'b0;
        step(3);
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL go_held_over_reset: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        go = 1'b0;
        step(1);
        pulse_go();
        exp_v = {16'h0000, 4'b1101, 1'b1, 1'b0};
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL go_after_rearm: got %h expected %h", obs, exp_v);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_up_wrap();
        test_down_wrap();
        test_pause_resume();
        test_clr_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
